// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller and its datapath/memory.
// The controller owns the strobes. The datapath owns the IR contents and mem_ready.
interface multicycle_controller_if #(
    parameter int ALU_OP_W = 3
);
    // Memory handshake: mem_read/mem_write act as "valid" and stay high while
    // the controller waits. mem_ready is "ready". An access completes on the
    // cycle where a strobe and mem_ready are both high. mem_ready has no
    // meaning while neither strobe is high.
    logic [31:0]         instruction;
    logic                mem_ready;
    logic                mem_read;
    logic                mem_write;
    logic                i_or_d;
    logic                ir_write;
    logic                pc_write;
    logic                pc_write_cond;
    logic                branch_ne;
    logic [1:0]          pc_source;
    logic [1:0]          alu_src_b;
    logic [ALU_OP_W-1:0] alu_op;
    logic [1:0]          reg_dst;
    logic [1:0]          mem_to_reg;
    logic                reg_write;
    logic                illegal;
    logic                timeout;
    logic [2:0]          state;

    modport master (
        input  instruction, mem_ready,
        output mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond,
               branch_ne, pc_source, alu_src_b, alu_op, reg_dst, mem_to_reg,
               reg_write, illegal, timeout, state
    );

    modport slave (
        output instruction, mem_ready,
        input  mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond,
               branch_ne, pc_source, alu_src_b, alu_op, reg_dst, mem_to_reg,
               reg_write, illegal, timeout, state
    );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle MIPS-style control FSM: FETCH/DECODE/EXEC/MEM/WB plus an absorbing TRAP.
// Optional macro MULTICYCLE_CONTROLLER_JAL_EN adds jal as a two-cycle jump-and-link.
module multicycle_controller #(
    parameter int ALU_OP_W  = 3,
    parameter int TIMEOUT_W = 4
) (
    input logic                    clk,
    input logic                    reset_n,
    multicycle_controller_if.master bus
);
    if (ALU_OP_W < 3) begin : gAluOpWidthCheck
        $error("multicycle_controller: ALU_OP_W must be at least 3");
    end

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;

    // Count value at which one more idle wait cycle reaches 2^TIMEOUT_W-1.
    localparam logic [TIMEOUT_W-1:0] WAIT_LAST = TIMEOUT_W'((2 ** TIMEOUT_W) - 2);

    state_t               state;
    logic [5:0]           opcodeReg;
    logic [TIMEOUT_W-1:0] waitCount;
    logic                 illegalReg;
    logic                 timeoutReg;

    logic [5:0] decOp;
    logic       decExec;
    logic       decJump;
    logic       decJal;
    logic       memWaiting;
    logic       waitExpire;

    // The IR is loaded at the end of FETCH, so during DECODE the opcode is taken
    // straight from the instruction bus. It is latched for the later states.
    assign decOp = bus.instruction[31:26];

`ifdef MULTICYCLE_CONTROLLER_JAL_EN
    assign decJal = (decOp == OP_JAL);
`else
    assign decJal = 1'b0;
`endif

    assign decJump = (decOp == OP_J) || decJal;

    always_comb begin
        decExec = 1'b0;
        case (decOp)
            OP_R, OP_LW, OP_SW, OP_ADDI, OP_ANDI, OP_ORI, OP_BEQ, OP_BNE: decExec = 1'b1;
            default: decExec = 1'b0;
        endcase
    end

    assign memWaiting = ((state == FETCH) || (state == MEM)) && !bus.mem_ready;
    assign waitExpire = memWaiting && (waitCount == WAIT_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= FETCH;
            opcodeReg  <= '0;
            waitCount  <= '0;
            illegalReg <= 1'b0;
            timeoutReg <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (bus.mem_ready) begin
                        state <= DECODE;
                    end else if (waitExpire) begin
                        state      <= TRAP;
                        timeoutReg <= 1'b1;
                    end
                end
                DECODE: begin
                    opcodeReg <= decOp;
                    if (decExec) begin
                        state <= EXEC;
                    end else if (decJump) begin
                        state <= FETCH;
                    end else begin
                        state      <= TRAP;
                        illegalReg <= 1'b1;
                    end
                end
                EXEC: begin
                    case (opcodeReg)
                        OP_LW, OP_SW:   state <= MEM;
                        OP_BEQ, OP_BNE: state <= FETCH;
                        default:        state <= WB;
                    endcase
                end
                MEM: begin
                    if (bus.mem_ready) begin
                        state <= (opcodeReg == OP_LW) ? WB : FETCH;
                    end else if (waitExpire) begin
                        state      <= TRAP;
                        timeoutReg <= 1'b1;
                    end
                end
                WB:      state <= FETCH;
                TRAP:    state <= TRAP;
                default: state <= TRAP;
            endcase

            // Any state change or completed access restarts the wait count.
            if (memWaiting && !waitExpire) begin
                waitCount <= waitCount + 1'b1;
            end else begin
                waitCount <= '0;
            end
        end
    end

    assign bus.state   = state;
    assign bus.illegal = illegalReg;
    assign bus.timeout = timeoutReg;

    always_comb begin
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.i_or_d        = 1'b0;
        bus.ir_write      = 1'b0;
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.branch_ne     = 1'b0;
        bus.pc_source     = 2'b00;
        bus.alu_src_b     = 2'b00;
        bus.alu_op        = '0;
        bus.reg_dst       = 2'b00;
        bus.mem_to_reg    = 2'b00;
        bus.reg_write     = 1'b0;
        // Strobes stay quiet for the whole reset, even though state reads FETCH.
        if (reset_n) begin
            case (state)
                FETCH: begin
                    bus.mem_read = 1'b1;
                    if (bus.mem_ready) begin
                        bus.ir_write  = 1'b1;
                        bus.pc_write  = 1'b1;
                        bus.alu_src_b = 2'b01;
                        bus.pc_source = 2'b00;
                    end
                end
                DECODE: begin
                    bus.alu_src_b = 2'b11;
                    if (decJump) begin
                        bus.pc_write  = 1'b1;
                        bus.pc_source = 2'b10;
                    end
                    if (decJal) begin
                        bus.reg_write  = 1'b1;
                        bus.reg_dst    = 2'b10;
                        bus.mem_to_reg = 2'b10;
                    end
                end
                EXEC: begin
                    case (opcodeReg)
                        OP_R: begin
                            bus.alu_op    = ALU_OP_W'(2);
                            bus.alu_src_b = 2'b00;
                        end
                        OP_LW, OP_SW, OP_ADDI: begin
                            bus.alu_op    = ALU_OP_W'(0);
                            bus.alu_src_b = 2'b10;
                        end
                        OP_ANDI: begin
                            bus.alu_op    = ALU_OP_W'(3);
                            bus.alu_src_b = 2'b10;
                        end
                        OP_ORI: begin
                            bus.alu_op    = ALU_OP_W'(4);
                            bus.alu_src_b = 2'b10;
                        end
                        OP_BEQ, OP_BNE: begin
                            bus.alu_op        = ALU_OP_W'(1);
                            bus.alu_src_b     = 2'b00;
                            bus.pc_write_cond = 1'b1;
                            bus.branch_ne     = opcodeReg[0];
                            bus.pc_source     = 2'b01;
                        end
                        default: ;
                    endcase
                end
                MEM: begin
                    bus.i_or_d    = 1'b1;
                    bus.mem_read  = (opcodeReg == OP_LW);
                    bus.mem_write = (opcodeReg == OP_SW);
                end
                WB: begin
                    bus.reg_write  = 1'b1;
                    bus.reg_dst    = (opcodeReg == OP_R)  ? 2'b01 : 2'b00;
                    bus.mem_to_reg = (opcodeReg == OP_LW) ? 2'b01 : 2'b00;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: directed and random instructions checked cycle by cycle
// against per-instruction expected output plans (MULTICYCLE_CONTROLLER_JAL_EN aware).
module tb_multicycle_controller;
  localparam int TMO_W    = 4;
  localparam int WAIT_MAX = (1 << TMO_W) - 1;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_ne;
    logic [1:0] pc_source;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       reg_write;
    logic       illegal;
    logic       timeout;
    logic [2:0] state;
  } obs_t;

  localparam int OBS_W = $bits(obs_t);

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  multicycle_controller_if #(.ALU_OP_W(3)) bus ();

  multicycle_controller #(.ALU_OP_W(3), .TIMEOUT_W(TMO_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.master)
  );

  obs_t act;
  assign act = {bus.mem_read, bus.mem_write, bus.i_or_d, bus.ir_write, bus.pc_write,
                bus.pc_write_cond, bus.branch_ne, bus.pc_source, bus.alu_src_b, bus.alu_op,
                bus.reg_dst, bus.mem_to_reg, bus.reg_write, bus.illegal, bus.timeout, bus.state};

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [OBS_W-1:0] exp_q[$];
  logic             rdy_q[$];
  logic             exp_ill;
  logic             exp_tmo;
  logic [31:0]      cur_ins;
  string            cur_name;

  task automatic check(input obs_t exp, input string tag);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, act, exp);
    end
  endtask

  // ---------------- reference model: per-instruction output plan ----------------
  function automatic obs_t blank(input logic [2:0] st);
    obs_t o;
    o = '0;
    o.state   = st;
    o.illegal = exp_ill;
    o.timeout = exp_tmo;
    return o;
  endfunction

  task automatic push(input logic r, input obs_t o);
    rdy_q.push_back(r);
    exp_q.push_back(o);
  endtask

  task automatic push_trap(input int n);
    for (int i = 0; i < n; i++) push(1'($urandom_range(0, 1)), blank(3'd5));
  endtask

  // w idle cycles of a memory access; the 15th consecutive idle cycle traps.
  task automatic wait_phase(input obs_t busy, input int w, output bit trapped);
    trapped = 1'b0;
    for (int i = 0; i < w && i < WAIT_MAX; i++) push(1'b0, busy);
    if (w >= WAIT_MAX) begin
      exp_tmo = 1'b1;
      push_trap(5);
      trapped = 1'b1;
    end
  endtask

  task automatic plan(input logic [31:0] ins, input int fw, input int mw);
    logic [5:0] op;
    obs_t o;
    bit trapped;
    op = ins[31:26];
    o = blank(3'd0);
    o.mem_read = 1'b1;
    wait_phase(o, fw, trapped);
    if (trapped) return;
    o.ir_write = 1'b1; o.pc_write = 1'b1; o.alu_src_b = 2'b01; o.pc_source = 2'b00;
    push(1'b1, o);

    o = blank(3'd1);
    o.alu_src_b = 2'b11;
    if (op == OP_J) begin
      o.pc_write = 1'b1; o.pc_source = 2'b10;
      push(1'($urandom_range(0, 1)), o);
      return;
    end
`ifdef MULTICYCLE_CONTROLLER_JAL_EN
    if (op == OP_JAL) begin
      o.pc_write = 1'b1; o.pc_source = 2'b10;
      o.reg_write = 1'b1; o.reg_dst = 2'b10; o.mem_to_reg = 2'b10;
      push(1'($urandom_range(0, 1)), o);
      return;
    end
`endif
    push(1'($urandom_range(0, 1)), o);
    if (!(op inside {OP_R, OP_LW, OP_SW, OP_ADDI, OP_ANDI, OP_ORI, OP_BEQ, OP_BNE})) begin
      exp_ill = 1'b1;
      push_trap(20);
      return;
    end

    o = blank(3'd2);
    if (op == OP_R) begin o.alu_op = 3'd2; o.alu_src_b = 2'b00; end
    else if (op inside {OP_LW, OP_SW, OP_ADDI}) begin o.alu_op = 3'd0; o.alu_src_b = 2'b10; end
    else if (op == OP_ANDI) begin o.alu_op = 3'd3; o.alu_src_b = 2'b10; end
    else if (op == OP_ORI) begin o.alu_op = 3'd4; o.alu_src_b = 2'b10; end
    else begin
      o.alu_op = 3'd1; o.alu_src_b = 2'b00; o.pc_write_cond = 1'b1;
      o.branch_ne = (op == OP_BNE); o.pc_source = 2'b01;
    end
    push(1'($urandom_range(0, 1)), o);
    if (op inside {OP_BEQ, OP_BNE}) return;

    if (op inside {OP_LW, OP_SW}) begin
      o = blank(3'd3);
      o.i_or_d = 1'b1;
      o.mem_read = (op == OP_LW);
      o.mem_write = (op == OP_SW);
      wait_phase(o, mw, trapped);
      if (trapped) return;
      push(1'b1, o);
      if (op == OP_SW) return;
    end

    o = blank(3'd4);
    o.reg_write = 1'b1;
    o.reg_dst = (op == OP_R) ? 2'b01 : 2'b00;
    o.mem_to_reg = (op == OP_LW) ? 2'b01 : 2'b00;
    push(1'($urandom_range(0, 1)), o);
  endtask

  // ---------------- driver tasks ----------------
  task automatic exec_q(input int limit);
    int n;
    obs_t e;
    n = 0;
    while (exp_q.size() > 0 && n < limit) begin
      @(negedge clk);
      bus.instruction = cur_ins;
      bus.mem_ready = rdy_q.pop_front();
      #1;
      e = obs_t'(exp_q.pop_front());
      check(e, $sformatf("%s c%0d", cur_name, n));
      n++;
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #1;
    reset_n = 1'b0;
    bus.mem_ready = 1'b1;
    #1;
    check('0, "reset_async");
    @(posedge clk);
    #1;
    check('0, "reset_hold");
    #1;
    reset_n = 1'b1;
    exp_q.delete();
    rdy_q.delete();
    exp_ill = 1'b0;
    exp_tmo = 1'b0;
  endtask

  task automatic run(input string name, input logic [31:0] ins, input int fw, input int mw);
    cur_name = name;
    cur_ins = ins;
    plan(ins, fw, mw);
    exec_q(1000);
    if (exp_ill || exp_tmo) pulse_reset();
  endtask

  function automatic bit is_known(input logic [5:0] op);
    if (op inside {OP_R, OP_LW, OP_SW, OP_ADDI, OP_ANDI, OP_ORI, OP_BEQ, OP_BNE, OP_J}) return 1'b1;
`ifdef MULTICYCLE_CONTROLLER_JAL_EN
    if (op == OP_JAL) return 1'b1;
`endif
    return 1'b0;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [5:0] ops[10];
    logic [5:0] op;
    ops = '{OP_R, OP_LW, OP_SW, OP_ADDI, OP_ANDI, OP_ORI, OP_BEQ, OP_BNE, OP_J, OP_JAL};
    reset_n = 1'b0;
    bus.instruction = '0;
    bus.mem_ready = 1'b0;
    exp_ill = 1'b0;
    exp_tmo = 1'b0;
    cur_ins = '0;
    cur_name = "init";
    #3;
    check('0, "reset_init");
    pulse_reset();

    run("add",     32'h012A4020, 0, 0);
    run("lw_wait", 32'h8D090004, 0, 3);
    run("bne",     32'h15090003, 0, 0);
    run("beq",     32'h11090003, 2, 0);
    run("sw",      32'hAD090008, 1, 2);
    run("addi",    32'h21290005, 0, 0);
    run("andi",    32'h3129000F, 3, 0);
    run("ori",     32'h352900F0, 0, 0);
    run("j",       32'h08000040, 1, 0);
    run("jal",     32'h0C000010, 0, 0);
    run("add_after_jal", 32'h012A4020, 0, 0);
    run("illegal", 32'hFC000000, 0, 0);
    run("fetch_tmo", 32'h012A4020, WAIT_MAX, 0);
    run("fetch_14w", 32'h012A4020, WAIT_MAX - 1, 0);
    run("lw_mem_tmo", 32'h8D090004, 0, WAIT_MAX);
    run("sw_mem_14w", 32'hAD090008, 0, WAIT_MAX - 1);

    cur_name = "lw_midreset";
    cur_ins = 32'h8D090004;
    plan(cur_ins, 0, 6);
    exec_q(5);
    pulse_reset();
    run("add_after_reset", 32'h012A4020, 0, 0);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        op = 6'($urandom_range(0, 63));
        while (is_known(op)) op = 6'($urandom_range(0, 63));
      end else begin
        op = ops[$urandom_range(0, 9)];
      end
      run($sformatf("rnd%0d", i), {op, 26'($urandom)}, $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
